// File: rtl/idct_2d_8x8_seq.sv
// idct_2d_8x8_seq
// Sequential 8x8 two-dimensional inverse DCT. A block is accepted in IDLE,
// a row pass fills the intermediate matrix one element per cycle, then a
// column pass fills the output matrix one element per cycle. Both passes
// share one bank of eight multipliers, a 64-entry cosine table, and one
// round/saturate stage.
module idct_2d_8x8_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int COEFF_FRAC = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*64-1:0]   data_in_matrix,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*64-1:0]   data_out_matrix,
  output logic                       busy
);

  localparam int N     = 64;
  localparam int KW    = COEFF_FRAC + 2;
  localparam int PW    = DATA_WIDTH + KW;
  localparam int ACC_W = DATA_WIDTH + COEFF_FRAC + 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_COL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // cos(m*pi/16) scaled by 2^29, for m = 0..8. Kept at high precision so the
  // table below can be re-rounded for any COEFF_FRAC up to 29.
  function automatic longint cos_q29(input int m);
    case (m)
      0:       return 64'sd536870912;
      1:       return 64'sd526555088;
      2:       return 64'sd496004046;
      3:       return 64'sd446391848;
      4:       return 64'sd379625062;
      5:       return 64'sd298269496;
      6:       return 64'sd205451603;
      7:       return 64'sd104738318;
      default: return 64'sd0;
    endcase
  endfunction

  // Builds k(u,n) = round(2^COEFF_FRAC * C(u)/2 * cos((2n+1)u*pi/16)) for all
  // u,n, packed with entry (u*8+n) at bits [(u*8+n)*KW +: KW]. The DC basis
  // C(0)/2 equals cos(pi/4)/2, so it reuses the m=4 entry.
  function automatic logic [N*KW-1:0] build_ktab();
    logic [N*KW-1:0] t;
    longint          v;
    longint          q;
    int              m;
    t = '0;
    for (int u = 0; u < 8; u++) begin
      for (int n = 0; n < 8; n++) begin
        m = ((2 * n + 1) * u) % 32;
        if (u == 0)       v = cos_q29(4);
        else if (m <= 8)  v = cos_q29(m);
        else if (m <= 16) v = -cos_q29(16 - m);
        else if (m <= 24) v = -cos_q29(m - 16);
        else              v = cos_q29(32 - m);
        q = (v + (64'sd1 <<< (29 - COEFF_FRAC))) >>> (30 - COEFF_FRAC);
        t[(u * 8 + n) * KW +: KW] = q[KW-1:0];
      end
    end
    return t;
  endfunction

  localparam logic [N*KW-1:0] KTAB = build_ktab();

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd1 <<< (COEFF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  // Cosine constant k(u,n).
  function automatic logic signed [KW-1:0] kcoef(input logic [2:0] u, input logic [2:0] n);
    return $signed(KTAB[(int'(u) * 8 + int'(n)) * KW +: KW]);
  endfunction

  // Round half up at the binary point, then clamp to the signed sample range.
  function automatic logic signed [DATA_WIDTH-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = (a + RND_HALF) >>> COEFF_FRAC;
    if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return s[DATA_WIDTH-1:0];
  endfunction

  state_t                        state_q, state_d;
  logic [5:0]                    idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  in_q  [N];
  logic signed [DATA_WIDTH-1:0]  tmp_q [N];
  logic signed [DATA_WIDTH-1:0]  out_q [N];

  logic [2:0]                    hi, lo;
  logic signed [DATA_WIDTH-1:0]  opnd [8];
  logic signed [KW-1:0]          coef [8];
  logic signed [PW-1:0]          prod [8];
  logic signed [ACC_W-1:0]       acc;
  logic signed [DATA_WIDTH-1:0]  res;
  logic                          accept;

  assign hi     = idx_q[5:3];
  assign lo     = idx_q[2:0];
  assign accept = (state_q == S_IDLE) && in_valid;
  assign res    = rnd_sat(acc);

  // State and element-index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, index sequencing and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_ROW;
          idx_d   = '0;
        end
      end
      S_ROW: begin
        busy = 1'b1;
        if (idx_q == 6'd63) begin
          state_d = S_COL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_COL: begin
        busy = 1'b1;
        if (idx_q == 6'd63) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared 8-tap dot product: row pass walks input row r against k(u,x),
  // column pass walks intermediate column x against k(v,y).
  always_comb begin
    acc = '0;
    for (int j = 0; j < 8; j++) begin
      if (state_q == S_ROW) begin
        opnd[j] = in_q[{hi, 3'(j)}];
        coef[j] = kcoef(3'(j), lo);
      end else begin
        opnd[j] = tmp_q[{3'(j), lo}];
        coef[j] = kcoef(3'(j), hi);
      end
      prod[j] = PW'(opnd[j]) * PW'(coef[j]);
      acc     = acc + ACC_W'(prod[j]);
    end
  end

  // Input capture, intermediate and output matrices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        in_q[i]  <= '0;
        tmp_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          in_q[i] <= data_in_matrix[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (state_q == S_ROW) tmp_q[idx_q] <= res;
      if (state_q == S_COL) out_q[idx_q] <= res;
    end
  end

  // Flatten the output matrix row-major.
  always_comb begin
    data_out_matrix = '0;
    for (int i = 0; i < N; i++) begin
      data_out_matrix[i*DATA_WIDTH +: DATA_WIDTH] = out_q[i];
    end
  end

endmodule
